// File: rtl/dma_req_seq_mux.sv
// N-channel round-robin DMA request arbiter with an in-order grant queue that
// steers the data-path mux beat by beat and pulses done after each transfer.
module dma_req_seq_mux #(
  parameter int N_CHAN    = 4,
  parameter int CHAN_BITS = $clog2(N_CHAN),
  parameter int DATA_BITS = 512,
  parameter int ADDR_BITS = 64,
  parameter int LEN_BITS  = 28,
  parameter int SEQ_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_CHAN-1:0]             s_req_valid,
  output logic [N_CHAN-1:0]             s_req_ready,
  input  logic [N_CHAN*ADDR_BITS-1:0]   s_req_addr,
  input  logic [N_CHAN*LEN_BITS-1:0]    s_req_len,
  input  logic [N_CHAN-1:0]             s_req_ctl,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [ADDR_BITS-1:0]          m_req_addr,
  output logic [LEN_BITS-1:0]           m_req_len,
  output logic                          m_req_ctl,
  output logic [CHAN_BITS-1:0]          m_req_vfid,
  input  logic                          data_beat,
  output logic                          mux_valid,
  output logic [CHAN_BITS-1:0]          mux_vfid,
  output logic                          mux_ctl,
  output logic                          mux_done,
  output logic [$clog2(SEQ_DEPTH):0]    seq_count,
  output logic                          err_beat
);
  localparam int BYTES = DATA_BITS / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int BW    = LEN_BITS + 1;
  localparam int PW    = $clog2(SEQ_DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [CHAN_BITS-1:0] vfid;
    logic [BW-1:0]        beats;
    logic                 ctl;
  } seq_ent_t;

  typedef enum logic {S_IDLE, S_ACTIVE} trk_t;

  logic [CHAN_BITS-1:0] rr_ptr, win;
  logic [CHAN_BITS:0]   cand;
  logic                 any, acc, pop, last;
  logic [LEN_BITS-1:0]  w_len;
  logic [BW-1:0]        w_beats;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  seq_ent_t             mem [SEQ_DEPTH];
  seq_ent_t             head;
  trk_t                 state;
  logic [BW-1:0]        beat_cnt, cur_beats;

  // Round-robin search starting at rr_ptr; first valid channel wins.
  always_comb begin
    any  = 1'b0;
    win  = '0;
    cand = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      cand = {1'b0, rr_ptr} + (CHAN_BITS+1)'(i);
      if (cand >= (CHAN_BITS+1)'(N_CHAN)) cand = cand - (CHAN_BITS+1)'(N_CHAN);
      if (!any && s_req_valid[cand[CHAN_BITS-1:0]]) begin
        any = 1'b1;
        win = cand[CHAN_BITS-1:0];
      end
    end
  end

  assign acc = any && (!m_req_valid || m_req_ready) && (seq_count != CW'(SEQ_DEPTH));

  always_comb begin
    s_req_ready = '0;
    if (acc) s_req_ready[win] = 1'b1;
  end

  // Beat count rounds up; a zero-length request still occupies one beat.
  assign w_len = s_req_len[win*LEN_BITS +: LEN_BITS];
  always_comb begin
    w_beats = ({1'b0, w_len} + BW'(BYTES-1)) >> BSH;
    if (w_beats == '0) w_beats = BW'(1);
  end

  assign head = mem[rd_ptr];
  assign last = (state == S_ACTIVE) && data_beat && (beat_cnt == cur_beats - BW'(1));
  assign pop  = (seq_count != '0) && ((state == S_IDLE) || last);

  always_ff @(posedge aclk)
    if (acc) mem[wr_ptr] <= '{vfid: win, beats: w_beats, ctl: s_req_ctl[win]};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr      <= '0;
      m_req_valid <= 1'b0;
      m_req_addr  <= '0;
      m_req_len   <= '0;
      m_req_ctl   <= 1'b0;
      m_req_vfid  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      seq_count   <= '0;
      state       <= S_IDLE;
      beat_cnt    <= '0;
      cur_beats   <= '0;
      mux_valid   <= 1'b0;
      mux_vfid    <= '0;
      mux_ctl     <= 1'b0;
      mux_done    <= 1'b0;
      err_beat    <= 1'b0;
    end else begin
      if (acc) begin
        rr_ptr      <= (win == CHAN_BITS'(N_CHAN-1)) ? '0 : win + 1'b1;
        m_req_valid <= 1'b1;
        m_req_addr  <= s_req_addr[win*ADDR_BITS +: ADDR_BITS];
        m_req_len   <= w_len;
        m_req_ctl   <= s_req_ctl[win];
        m_req_vfid  <= win;
        wr_ptr      <= wr_ptr + 1'b1;
      end else if (m_req_ready) begin
        m_req_valid <= 1'b0;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({acc, pop})
        2'b10:   seq_count <= seq_count + CW'(1);
        2'b01:   seq_count <= seq_count - CW'(1);
        default: ;
      endcase

      mux_done <= 1'b0;
      if (data_beat && state == S_IDLE) err_beat <= 1'b1;
      if (state == S_ACTIVE && data_beat && !last) beat_cnt <= beat_cnt + BW'(1);
      if (last) mux_done <= 1'b1;
      // A pop either starts the first transfer or chains straight into the next.
      if (pop) begin
        state     <= S_ACTIVE;
        mux_valid <= 1'b1;
        mux_vfid  <= head.vfid;
        mux_ctl   <= head.ctl;
        cur_beats <= head.beats;
        beat_cnt  <= '0;
      end else if (last) begin
        state     <= S_IDLE;
        mux_valid <= 1'b0;
        beat_cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dma_req_seq_mux.sv
// Random/directed bench for dma_req_seq_mux against a transaction-level queue model.
module tb_dma_req_seq_mux;
  localparam int N = 4, CB = 2, DB = 512, AB = 64, LB = 28, SD = 8, BYTES = DB / 8;

  logic            aclk, aresetn;
  logic [N-1:0]    s_req_valid, s_req_ready, s_req_ctl;
  logic [N*AB-1:0] s_req_addr;
  logic [N*LB-1:0] s_req_len;
  logic            m_req_valid, m_req_ready, m_req_ctl;
  logic [AB-1:0]   m_req_addr;
  logic [LB-1:0]   m_req_len;
  logic [CB-1:0]   m_req_vfid, mux_vfid;
  logic            data_beat, mux_valid, mux_ctl, mux_done, err_beat;
  logic [3:0]      seq_count;

  dma_req_seq_mux #(.N_CHAN(N), .CHAN_BITS(CB), .DATA_BITS(DB), .ADDR_BITS(AB),
                    .LEN_BITS(LB), .SEQ_DEPTH(SD)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_len(s_req_len), .s_req_ctl(s_req_ctl),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_len(m_req_len), .m_req_ctl(m_req_ctl), .m_req_vfid(m_req_vfid),
    .data_beat(data_beat), .mux_valid(mux_valid), .mux_vfid(mux_vfid),
    .mux_ctl(mux_ctl), .mux_done(mux_done), .seq_count(seq_count), .err_beat(err_beat));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct { int vfid; int beats; bit ctl; } xfer_t;
  xfer_t       q[$];
  xfer_t       cur;
  int          rr, mlen, mvfid, t_rem;
  bit          mv, mctl, t_act, done_e, err_e;
  logic [63:0] maddr;
  int          nvec, nerr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_arb(output bit acc, output int win);
    bit found;
    acc = 0; win = 0; found = 0;
    if ((!mv || m_req_ready) && q.size() < SD)
      for (int i = 0; i < N; i++)
        if (!found && s_req_valid[(rr + i) % N]) begin
          found = 1; acc = 1; win = (rr + i) % N;
        end
  endtask

  task automatic model_clk();
    bit acc; int win, len; xfer_t nx;
    if (!aresetn) begin
      q.delete(); rr = 0; mv = 0; maddr = 0; mlen = 0; mctl = 0; mvfid = 0;
      t_act = 0; t_rem = 0; done_e = 0; err_e = 0;
      return;
    end
    model_arb(acc, win);
    done_e = 0;
    if (!t_act) begin
      if (data_beat) err_e = 1;
      if (q.size() > 0) begin cur = q.pop_front(); t_rem = cur.beats; t_act = 1; end
    end else if (data_beat) begin
      t_rem--;
      if (t_rem == 0) begin
        done_e = 1;
        if (q.size() > 0) begin cur = q.pop_front(); t_rem = cur.beats; end
        else t_act = 0;
      end
    end
    if (acc) begin
      len = int'(s_req_len[win*LB +: LB]);
      nx.vfid = win;
      nx.beats = (len == 0) ? 1 : (len + BYTES - 1) / BYTES;
      nx.ctl = s_req_ctl[win];
      q.push_back(nx);
      mv = 1; maddr = s_req_addr[win*AB +: AB]; mlen = len; mctl = nx.ctl; mvfid = win;
      rr = (win + 1) % N;
    end else if (m_req_ready) mv = 0;
  endtask

  task automatic check_outs();
    chk("m_req_valid", m_req_valid, mv);
    if (mv) begin
      chk("m_req_addr", m_req_addr, maddr);
      chk("m_req_len", m_req_len, mlen);
      chk("m_req_ctl", m_req_ctl, mctl);
      chk("m_req_vfid", m_req_vfid, mvfid);
    end
    chk("mux_valid", mux_valid, t_act);
    if (t_act) begin
      chk("mux_vfid", mux_vfid, cur.vfid);
      chk("mux_ctl", mux_ctl, cur.ctl);
    end
    chk("mux_done", mux_done, done_e);
    chk("err_beat", err_beat, err_e);
    chk("seq_count", seq_count, q.size());
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    bit acc; int win; logic [N-1:0] exp_rdy;
    #1;
    model_arb(acc, win);
    exp_rdy = '0;
    if (acc) exp_rdy[win] = 1'b1;
    chk("s_req_ready", s_req_ready, exp_rdy);
    @(posedge aclk);
    model_clk();
    #1;
    check_outs();
    @(negedge aclk);
  endtask

  function automatic int pick_len();
    case ($urandom % 6)
      0: return 0;
      1: return 1;
      2: return 64;
      3: return 65;
      4: return 128;
      default: return int'($urandom % 400);
    endcase
  endfunction

  task automatic drive(input int pv, input int pr, input int pb, input bit beat_if_active);
    for (int i = 0; i < N; i++) begin
      s_req_valid[i] = ($urandom % 100) < pv;
      s_req_addr[i*AB +: AB] = {$urandom, $urandom};
      s_req_len[i*LB +: LB] = LB'(pick_len());
      s_req_ctl[i] = $urandom % 2;
    end
    m_req_ready = ($urandom % 100) < pr;
    data_beat = (($urandom % 100) < pb) && (!beat_if_active || t_act);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    aresetn = 0; s_req_valid = '0; s_req_addr = '0; s_req_len = '0; s_req_ctl = '0;
    m_req_ready = 0; data_beat = 0;
    q.delete(); rr = 0; mv = 0; maddr = 0; mlen = 0; mctl = 0; mvfid = 0;
    t_act = 0; t_rem = 0; done_e = 0; err_e = 0;
    @(negedge aclk);
    step(); step();
    chk("rst_m_req_addr", m_req_addr, 0);
    chk("rst_mux_vfid", mux_vfid, 0);
    aresetn = 1;

    // Single request ch2, len=128 -> two beats.
    s_req_valid = 4'b0100; s_req_len[2*LB +: LB] = 128; s_req_addr[2*AB +: AB] = 64'h1234_5678_9abc_def0;
    m_req_ready = 1;
    step();
    s_req_valid = '0;
    step();
    chk("single_vfid", m_req_vfid, 2);
    for (int i = 0; i < 5; i++) begin data_beat = t_act; step(); end
    data_beat = 0;
    step();

    // All channels continuously valid: rotation, then ready stall, then queue fill.
    for (int i = 0; i < 6; i++) begin drive(100, 100, 0, 1); step(); end
    for (int i = 0; i < 6; i++) begin drive(100, 0, 0, 1); step(); end
    for (int i = 0; i < 8; i++) begin drive(100, 100, 0, 1); step(); end
    chk("full_count", seq_count, SD);
    for (int i = 0; i < 40; i++) begin drive(100, 100, 70, 1); step(); end

    // Mixed traffic with beats only while a transfer is active.
    for (int i = 0; i < 300; i++) begin drive(40, 70, 60, 1); step(); end

    // Drain, then a beat while idle sets the sticky error.
    for (int i = 0; i < 150; i++) begin drive(0, 100, 100, 1); step(); end
    data_beat = 1; step();
    data_beat = 0; step(); step();
    chk("err_sticky", err_beat, 1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 20; i++) begin drive(60, 70, 50, 1); step(); end
    aresetn = 0; drive(0, 0, 0, 1); step();
    chk("midrst_count", seq_count, 0);
    chk("midrst_err", err_beat, 0);
    aresetn = 1;

    // Fully random, including stray beats.
    for (int i = 0; i < 300; i++) begin drive(50, 60, 50, 0); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
